i2c_cfg_seq: RTL and testbench

I2C_CFG_SEQ -- requirements
Module: i2c_cfg_seq

---
 rtl/i2c_cfg_seq.sv | 274 +++++++++++++++++++++++++++
 tb/tb_i2c_cfg_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cfg_seq.sv
// ---------------------------------------------------------------------------
// i2c_cfg_seq
//   Power-up configuration sequencer. After reset it waits PWR_DLY cycles, then
//   walks a small fixed register table and issues one I2C write per entry
//   through an external byte-level I2C driver. NACKs and missing completions
//   are retried up to RETRY_MAX times per entry before the sequence gives up.
//
//   Optional feature macro: I2C_CFG_READBACK_EN
//     When defined, each successful write is followed by a read of the same
//     register. The entry only counts as done once the read data matches the
//     table. A mismatch is treated like a NACK and the write is re-issued.
//
// Ports
//   sys_clk      : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : one-cycle restart request (honoured only when not busy)
//   w_enable     : one-cycle write request to the I2C driver
//   r_enable     : one-cycle read request to the I2C driver (0 without readback)
//   slave_addr   : {SLAVE_ADDR, R/W}
//   i2c_addr     : register address of the current entry
//   i2c_data_w   : write data of the current entry
//   i2c_data_r   : read data from the driver, valid with i2c_done
//   i2c_done     : one-cycle end-of-transaction pulse from the driver
//   i2c_ack_err  : NACK flag, qualified by i2c_done
//   cfg_busy     : sequence in progress
//   cfg_done     : table written successfully
//   cfg_err      : sequence aborted after exhausting retries
//   err_idx      : index of the entry that failed
// ---------------------------------------------------------------------------
module i2c_cfg_seq #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h7A,
    parameter int unsigned NUM_REGS   = 4,
    parameter int unsigned PWR_DLY    = 1000,
    parameter int unsigned GAP_DLY    = 100,
    parameter int unsigned TIMEOUT    = 65535,
    parameter int unsigned RETRY_MAX  = 3
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       w_enable,
    output logic       r_enable,
    output logic [7:0] slave_addr,
    output logic [7:0] i2c_addr,
    output logic [7:0] i2c_data_w,
    input  logic [7:0] i2c_data_r,
    input  logic       i2c_done,
    input  logic       i2c_ack_err,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [3:0] err_idx
);

    typedef enum logic [2:0] {
        IDLE,
        PWR_WAIT,
        ISSUE,
        WAIT_DONE,
        GAP,
        FIN,
        FAIL
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  retry_q, retry_d;
    logic        fin_pend_q, fin_pend_d;
    logic [7:0]  slave_addr_q, slave_addr_d;
    logic [7:0]  i2c_addr_q, i2c_addr_d;
    logic [7:0]  i2c_data_w_q, i2c_data_w_d;
    logic [3:0]  err_idx_q, err_idx_d;
`ifdef I2C_CFG_READBACK_EN
    logic        rd_q, rd_d;
`endif

    logic        txn_ok;
    logic        txn_fail;
    logic        advance;
    logic [15:0] entry_d;

    // Register table: {i2c_addr, data}. Unused indices read as zero.
    function automatic logic [15:0] rom_entry(input logic [3:0] i);
        case (i)
            4'd0:    return 16'h0501;
            4'd1:    return 16'h0623;
            4'd2:    return 16'h0745;
            4'd3:    return 16'h0867;
            default: return 16'h0000;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        fin_pend_d   = fin_pend_q;
        slave_addr_d = slave_addr_q;
        i2c_addr_d   = i2c_addr_q;
        i2c_data_w_d = i2c_data_w_q;
        err_idx_d    = err_idx_q;
`ifdef I2C_CFG_READBACK_EN
        rd_d         = rd_q;
`endif
        txn_ok       = 1'b0;
        txn_fail     = 1'b0;
        advance      = 1'b0;
        entry_d      = '0;

        case (state_q)
            IDLE, FIN, FAIL: begin
                if (start) begin
                    state_d    = ISSUE;
                    idx_d      = '0;
                    retry_d    = '0;
                    fin_pend_d = 1'b0;
                    err_idx_d  = '0;
`ifdef I2C_CFG_READBACK_EN
                    rd_d       = 1'b0;
`endif
                end
            end

            PWR_WAIT: begin
                if ((cnt_q + 32'd1) >= 32'(PWR_DLY)) begin
                    state_d    = ISSUE;
                    idx_d      = '0;
                    retry_d    = '0;
                    fin_pend_d = 1'b0;
`ifdef I2C_CFG_READBACK_EN
                    rd_d       = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            // The timeout window starts with the enable cycle, so the
            // ISSUE cycle already counts as cycle 0 of the wait.
            ISSUE: begin
                state_d = WAIT_DONE;
                cnt_d   = 32'd1;
            end

            WAIT_DONE: begin
                if (i2c_done) begin
                    if (i2c_ack_err) begin
                        txn_fail = 1'b1;
`ifdef I2C_CFG_READBACK_EN
                    end else if (rd_q && (i2c_data_r != rom_entry(idx_q)[7:0])) begin
                        txn_fail = 1'b1;
`endif
                    end else begin
                        txn_ok = 1'b1;
                    end
                end else if ((cnt_q + 32'd1) >= 32'(TIMEOUT)) begin
                    txn_fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end

                if (txn_ok) begin
                    state_d = GAP;
                    cnt_d   = '0;
`ifdef I2C_CFG_READBACK_EN
                    // A good write is followed by its readback; only a good
                    // readback moves on to the next entry.
                    rd_d    = ~rd_q;
                    advance = rd_q;
`else
                    advance = 1'b1;
`endif
                    if (advance) begin
                        if (idx_q == 4'(NUM_REGS - 1)) begin
                            fin_pend_d = 1'b1;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            retry_d = '0;
                        end
                    end
                end else if (txn_fail) begin
                    if (retry_q < 8'(RETRY_MAX)) begin
                        retry_d = retry_q + 8'd1;
                        state_d = GAP;
                        cnt_d   = '0;
`ifdef I2C_CFG_READBACK_EN
                        rd_d    = 1'b0;
`endif
                    end else begin
                        state_d   = FAIL;
                        err_idx_d = idx_q;
                    end
                end
            end

            GAP: begin
                if ((cnt_q + 32'd1) >= 32'(GAP_DLY)) begin
                    state_d = fin_pend_q ? FIN : ISSUE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Transaction fields are loaded on entry to ISSUE and then held until
        // the next ISSUE, which keeps them stable across WAIT_DONE.
        if (state_d == ISSUE) begin
            entry_d      = rom_entry(idx_d);
            i2c_addr_d   = entry_d[15:8];
            i2c_data_w_d = entry_d[7:0];
`ifdef I2C_CFG_READBACK_EN
            slave_addr_d = {SLAVE_ADDR, rd_d};
`else
            slave_addr_d = {SLAVE_ADDR, 1'b0};
`endif
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PWR_WAIT;
            cnt_q        <= '0;
            idx_q        <= '0;
            retry_q      <= '0;
            fin_pend_q   <= 1'b0;
            slave_addr_q <= '0;
            i2c_addr_q   <= '0;
            i2c_data_w_q <= '0;
            err_idx_q    <= '0;
`ifdef I2C_CFG_READBACK_EN
            rd_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            retry_q      <= retry_d;
            fin_pend_q   <= fin_pend_d;
            slave_addr_q <= slave_addr_d;
            i2c_addr_q   <= i2c_addr_d;
            i2c_data_w_q <= i2c_data_w_d;
            err_idx_q    <= err_idx_d;
`ifdef I2C_CFG_READBACK_EN
            rd_q         <= rd_d;
`endif
        end
    end

`ifdef I2C_CFG_READBACK_EN
    assign w_enable = (state_q == ISSUE) && !rd_q;
    assign r_enable = (state_q == ISSUE) && rd_q;
`else
    logic unused_data_r;
    assign unused_data_r = ^i2c_data_r;
    assign w_enable      = (state_q == ISSUE);
    assign r_enable      = 1'b0;
`endif

    assign slave_addr = slave_addr_q;
    assign i2c_addr   = i2c_addr_q;
    assign i2c_data_w = i2c_data_w_q;
    assign err_idx    = err_idx_q;
    assign cfg_busy   = (state_q == PWR_WAIT) || (state_q == ISSUE) ||
                        (state_q == WAIT_DONE) || (state_q == GAP);
    assign cfg_done   = (state_q == FIN);
    assign cfg_err    = (state_q == FAIL);

endmodule

// File: tb/tb_i2c_cfg_seq.sv
`timescale 1ns/1ps
module tb_i2c_cfg_seq;

    localparam int unsigned P_NUM   = 4;
    localparam int unsigned P_PWR   = 10;
    localparam int unsigned P_GAP   = 5;
    localparam int unsigned P_TO    = 50;
    localparam int unsigned P_RETRY = 3;
    localparam logic [6:0]  P_SA    = 7'h7A;

    localparam logic [7:0] TBL_ADDR [4] = '{8'h05, 8'h06, 8'h07, 8'h08};
    localparam logic [7:0] TBL_DATA [4] = '{8'h01, 8'h23, 8'h45, 8'h67};

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       w_enable, r_enable;
    logic [7:0] slave_addr, i2c_addr, i2c_data_w;
    logic [7:0] i2c_data_r = 8'h00;
    logic       i2c_done = 1'b0;
    logic       i2c_ack_err = 1'b0;
    logic       cfg_busy, cfg_done, cfg_err;
    logic [3:0] err_idx;

    always #5 sys_clk = ~sys_clk;

    i2c_cfg_seq #(
        .SLAVE_ADDR (P_SA),
        .NUM_REGS   (P_NUM),
        .PWR_DLY    (P_PWR),
        .GAP_DLY    (P_GAP),
        .TIMEOUT    (P_TO),
        .RETRY_MAX  (P_RETRY)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .start       (start),
        .w_enable    (w_enable),
        .r_enable    (r_enable),
        .slave_addr  (slave_addr),
        .i2c_addr    (i2c_addr),
        .i2c_data_w  (i2c_data_w),
        .i2c_data_r  (i2c_data_r),
        .i2c_done    (i2c_done),
        .i2c_ack_err (i2c_ack_err),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .err_idx     (err_idx)
    );

    typedef struct {
        bit          rd;
        logic [7:0]  sa;
        logic [7:0]  addr;
        logic [7:0]  data;
        int unsigned cyc;
    } txn_t;

    txn_t log_q[$];
    txn_t exp_q[$];
    bit   exp_fail;
    int   exp_err_idx;

    int n_vec = 0;
    int n_err = 0;
    int unsigned cyc = 0;

    // Driver-model controls, set by the stimulus sequence
    int nack_idx = -1;
    int nack_cnt = 0;
    bit never_done = 1'b0;
    int rb_idx = -1;
    int lat_lo = 2;
    int lat_hi = 30;
    bit echo_en = 1'b0;
    int wr_att [4];

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: each entry gets up to RETRY_MAX+1 attempts; an attempt is a
    // write, plus (with readback) a read that must return the table data.
    task automatic build_model();
        bit ok;
        exp_q.delete();
        exp_fail = 1'b0;
        exp_err_idx = 0;
        for (int i = 0; i < int'(P_NUM); i++) begin
            txn_t t;
            ok = 1'b0;
            for (int a = 0; a <= int'(P_RETRY) && !ok; a++) begin
                t.rd = 1'b0; t.sa = {P_SA, 1'b0}; t.addr = TBL_ADDR[i]; t.data = TBL_DATA[i]; t.cyc = 0;
                exp_q.push_back(t);
                ok = !never_done && !(i == nack_idx && a < nack_cnt);
`ifdef I2C_CFG_READBACK_EN
                if (ok) begin
                    t.rd = 1'b1; t.sa = {P_SA, 1'b1};
                    exp_q.push_back(t);
                    ok = (i != rb_idx);
                end
`endif
            end
            if (!ok) begin
                exp_fail = 1'b1;
                exp_err_idx = i;
                break;
            end
        end
    endtask

    // I2C driver model: logs every enable, answers with done after a random
    // latency, and optionally sends a stray NACK-done pulse during the gap.
    initial begin
        bit         pend;
        bit         nack_now;
        int         cd;
        int         echo_cd;
        int         e;
        logic [7:0] rdata;
        txn_t       t;
        pend = 1'b0; nack_now = 1'b0; cd = 0; echo_cd = 0; rdata = 8'h00;
        forever begin
            @(negedge sys_clk);
            i2c_done = 1'b0;
            i2c_ack_err = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
                echo_cd = 0;
            end else if (w_enable || r_enable) begin
                chk("we_re_exclusive", 32'(w_enable & r_enable), 32'd0);
                t.rd = r_enable; t.sa = slave_addr; t.addr = i2c_addr; t.data = i2c_data_w; t.cyc = cyc;
                log_q.push_back(t);
                nack_now = 1'b0;
                rdata = 8'h00;
                e = int'(i2c_addr) - 5;
                if (e >= 0 && e < 4) begin
                    if (!r_enable) begin
                        if (e == nack_idx && wr_att[e] < nack_cnt) nack_now = 1'b1;
                        wr_att[e]++;
                    end else begin
                        rdata = (e == rb_idx) ? 8'h00 : TBL_DATA[e];
                    end
                end
                if (!never_done) begin
                    pend = 1'b1;
                    cd = int'($urandom_range(lat_hi, lat_lo));
                end
            end else if (pend) begin
                cd--;
                if (cd == 0) begin
                    chk("stable_slave_addr", 32'(slave_addr), 32'(log_q[$].sa));
                    chk("stable_i2c_addr", 32'(i2c_addr), 32'(log_q[$].addr));
                    chk("stable_data_w", 32'(i2c_data_w), 32'(log_q[$].data));
                    i2c_done = 1'b1;
                    i2c_ack_err = nack_now;
                    i2c_data_r = rdata;
                    pend = 1'b0;
                    if (echo_en) echo_cd = 2;
                end
            end else if (echo_cd > 0) begin
                echo_cd--;
                if (echo_cd == 0) begin
                    i2c_done = 1'b1;
                    i2c_ack_err = 1'b1;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_w_enable"}, 32'(w_enable), 32'd0);
        chk({tag, "_r_enable"}, 32'(r_enable), 32'd0);
        chk({tag, "_slave_addr"}, 32'(slave_addr), 32'h00);
        chk({tag, "_i2c_addr"}, 32'(i2c_addr), 32'h00);
        chk({tag, "_data_w"}, 32'(i2c_data_w), 32'h00);
        chk({tag, "_busy"}, 32'(cfg_busy), 32'd1);
        chk({tag, "_done"}, 32'(cfg_done), 32'd0);
        chk({tag, "_err"}, 32'(cfg_err), 32'd0);
        chk({tag, "_err_idx"}, 32'(err_idx), 32'd0);
    endtask

    task automatic clear_log();
        log_q.delete();
        for (int i = 0; i < 4; i++) wr_att[i] = 0;
    endtask

    task automatic wait_log(input string tag, input int n);
        for (int k = 0; k < 3000 && log_q.size() < n; k++) @(negedge sys_clk);
        chk({tag, "_wait_log"}, 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    // Restart from FIN/FAIL: the first enable must follow the start directly.
    task automatic restart_seq(input string tag);
        clear_log();
        build_model();
        pulse_start();
        chk({tag, "_start_w_enable"}, 32'(w_enable), 32'd1);
        chk({tag, "_start_busy"}, 32'(cfg_busy), 32'd1);
        chk({tag, "_start_done"}, 32'(cfg_done), 32'd0);
        chk({tag, "_start_err"}, 32'(cfg_err), 32'd0);
        chk({tag, "_start_err_idx"}, 32'(err_idx), 32'd0);
    endtask

    task automatic finish_seq(input string tag, input int unsigned rel, input bit chk_rel);
        for (int k = 0; k < 5000 && !(cfg_done || cfg_err); k++) @(negedge sys_clk);
        chk({tag, "_ends_in_time"}, 32'(cfg_done | cfg_err), 32'd1);
        repeat (100) @(negedge sys_clk);
        chk({tag, "_txn_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            chk({tag, "_txn_rd"}, 32'(log_q[i].rd), 32'(exp_q[i].rd));
            chk({tag, "_txn_slave_addr"}, 32'(log_q[i].sa), 32'(exp_q[i].sa));
            chk({tag, "_txn_addr"}, 32'(log_q[i].addr), 32'(exp_q[i].addr));
            if (!exp_q[i].rd) chk({tag, "_txn_data"}, 32'(log_q[i].data), 32'(exp_q[i].data));
        end
        if (chk_rel && log_q.size() > 0)
            chk({tag, "_pwr_dly"}, log_q[0].cyc - rel, P_PWR);
        chk({tag, "_cfg_done"}, 32'(cfg_done), 32'(!exp_fail));
        chk({tag, "_cfg_err"}, 32'(cfg_err), 32'(exp_fail));
        chk({tag, "_cfg_busy"}, 32'(cfg_busy), 32'd0);
        if (exp_fail) chk({tag, "_err_idx"}, 32'(err_idx), 32'(exp_err_idx));
    endtask

    initial begin
        int unsigned rel;

        // Power-on reset
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("por");

        // A: clean run from reset; stray start while busy, stray done in GAP
        echo_en = 1'b1;
        clear_log();
        build_model();
        rel = cyc;
        rst_n = 1'b1;
        wait_log("A", 2);
        repeat ($urandom_range(10, 0)) @(negedge sys_clk);
        pulse_start();
        finish_seq("A", rel, 1'b1);
        echo_en = 1'b0;

        // B: entry 2 NACKed on its first two attempts
        nack_idx = 2; nack_cnt = 2;
        restart_seq("B");
        finish_seq("B", 0, 1'b0);

        // C: permanent NACK on entry 1
        nack_idx = 1; nack_cnt = 99;
        restart_seq("C");
        finish_seq("C", 0, 1'b0);

        // D: driver never answers; retries spaced by TIMEOUT+GAP
        nack_idx = -1; nack_cnt = 0; never_done = 1'b1;
        restart_seq("D");
        finish_seq("D", 0, 1'b0);
        for (int i = 1; i < log_q.size(); i++)
            chk("D_retry_period", log_q[i].cyc - log_q[i-1].cyc, P_TO + P_GAP);
        never_done = 1'b0;

        // E: reset in the middle of a transaction, then start while busy
        lat_lo = 20; lat_hi = 20;
        restart_seq("E");
        wait_log("E", 2);
        repeat ($urandom_range(15, 1)) @(negedge sys_clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        repeat (3) @(negedge sys_clk);
        clear_log();
        lat_lo = 2; lat_hi = 30;
        build_model();
        rel = cyc;
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        pulse_start();
        finish_seq("E", rel, 1'b1);

`ifdef I2C_CFG_READBACK_EN
        // F: readback of entry 0 returns the wrong data every time
        rb_idx = 0;
        restart_seq("F");
        finish_seq("F", 0, 1'b0);
        rb_idx = -1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
